mem_sram36: RTL and testbench
=============================

// Module: mem_sram36
// PURPOSE
//  Memory responder on the MEM side of the cache: answers mem_read/mem_write requests
//  against an 18-bit-wide synchronous SRAM, splitting each 36-bit word into two halves.
//  Flags non-existent memory (NXM) for word addresses at or beyond MEMWORDS.
//  Sits between the cache MEM port and the board SRAM.
// PARAMETERS
//  MEMWORDS  262144  installed memory in 36-bit words; address >= MEMWORDS is NXM
//  SRAM_AW   19      SRAM address width; must equal log2(MEMWORDS)+1
//  RD_LAT    1       SRAM read latency in cycles after sram_en (legal 1..7)
// PORTS
//  clk             in   1          system clock
//  reset           in   1          synchronous, active-low (0 = reset)
//  mem_addr        in   `PADDR     physical word address (bit 35 LSB)
//  mem_write_data  in   `WORD      write data (bit 0 MSB)
//  mem_read        in   1          read request, level, held until ack/nxm
//  mem_write       in   1          write request, level, held until ack/nxm
//  mem_read_data   out  `WORD      read data, valid while mem_read_ack
//  mem_read_ack    out  1          one-cycle read completion pulse
//  mem_write_ack   out  1          one-cycle write completion pulse
//  mem_nxm         out  1          one-cycle non-existent-memory pulse
//  sram_addr       out  SRAM_AW    SRAM half-word address
//  sram_wdata      out  18         SRAM write data
//  sram_rdata      in   18         SRAM read data
//  sram_en         out  1          SRAM access strobe
//  sram_we         out  1          SRAM write enable (qualified by sram_en)
// BEHAVIOUR
//  - Reset (reset==0 at a clk edge, any state): state->IDLE; all outputs 0, incl.
//    mem_read_data. A write cut by reset may leave only its high half written.
//  - Mapping: word W = mem_addr low SRAM_AW-1 bits; bits 0:17 at sram_addr {W,0},
//    bits 18:35 at {W,1}. NXM test compares full mem_addr against MEMWORDS.
//  - IDLE: at edge, if mem_read (read wins if both asserted) or mem_write, latch addr and
//    write data; NXM address -> NXM, else read->RHI, write->WHI. No request: stay.
//  - RHI: sram_en=1, sram_we=0, addr {W,0}; -> RWH with counter=RD_LAT.
//  - RWH: counter decrements; in final cycle capture sram_rdata into
//    mem_read_data[0:17] -> RLO.
//  - RLO/RWL: same for {W,1}, capturing into [18:35]; -> ACK.
//  - WHI: sram_en=1, sram_we=1, addr {W,0}, data = bits 0:17 -> WLO.
//  - WLO: same, {W,1}, bits 18:35 -> ACK.
//  - ACK: pulse mem_read_ack or mem_write_ack (matching the op) one cycle -> IDLE.
//  - NXM: pulse mem_nxm one cycle, no SRAM access, mem_read_data unchanged -> IDLE.
//  - sram_en/sram_we are 0 in every state not listed as driving them.
//  - Latency, request visible in IDLE cycle T0: write ack at T0+3;
//    read ack at T0+3+2*RD_LAT; nxm at T0+1.
//  - Accepted op always completes even if request drops; inputs ignored outside IDLE.
//  - Back-to-back: request still high in IDLE after ack is a new request (new addr).
//  - mem_read_data changes only during reads; holds last word otherwise.
// TESTING
//  - Write 0o123456701234 to addr 5, read addr 5 -> sram {10}=0o123456, {11}=0o701234;
//    write_ack at T0+3; read_ack at T0+5 (RD_LAT=1) with data 0o123456701234.
//  - Read with mem_addr=MEMWORDS -> mem_nxm pulses at T0+1; no acks; sram_en stays 0.
//  - Cache-style 4-word line read, mem_read held, addr stepping 8..11 on each ack
//    -> exactly four read_ack pulses, each with its word's data.
//  - mem_read and mem_write both high -> read performed, sram_we never asserted.
//  - reset=0 during WLO -> next cycle IDLE, all outputs 0; RD_LAT=3 read -> ack at T0+9.

Source files
------------

// File: rtl/mem_sram36.sv
// Cache MEM-port responder: serves 36-bit word reads/writes from an 18-bit SRAM
// as two half-word accesses, and pulses NXM for addresses past installed memory.
module mem_sram36 #(
    parameter int MEMWORDS = 262144,
    parameter int SRAM_AW  = 19,
    parameter int RD_LAT   = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [14:35]       mem_addr,
    input  logic [0:35]        mem_write_data,
    input  logic               mem_read,
    input  logic               mem_write,
    output logic [0:35]        mem_read_data,
    output logic               mem_read_ack,
    output logic               mem_write_ack,
    output logic               mem_nxm,
    output logic [SRAM_AW-1:0] sram_addr,
    output logic [17:0]        sram_wdata,
    input  logic [17:0]        sram_rdata,
    output logic               sram_en,
    output logic               sram_we
);

    typedef enum logic [3:0] {
        IDLE, RHI, RWH, RLO, RWL, WHI, WLO, ACK, NXM
    } state_t;

    localparam logic [2:0] LAT = 3'(RD_LAT);

    state_t             state;
    logic [SRAM_AW-2:0] word;
    logic [0:35]        wdata;
    logic [2:0]         cnt;
    logic [21:0]        addr;
    logic               nxm_addr;

    assign addr     = mem_addr;
    assign nxm_addr = 32'(addr) >= 32'(MEMWORDS);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state         <= IDLE;
            word          <= '0;
            wdata         <= '0;
            cnt           <= '0;
            mem_read_data <= '0;
            mem_read_ack  <= 1'b0;
            mem_write_ack <= 1'b0;
            mem_nxm       <= 1'b0;
            sram_addr     <= '0;
            sram_wdata    <= '0;
            sram_en       <= 1'b0;
            sram_we       <= 1'b0;
        end else begin
            // Strobes and pulses are one-cycle unless a state re-asserts them
            mem_read_ack  <= 1'b0;
            mem_write_ack <= 1'b0;
            mem_nxm       <= 1'b0;
            sram_en       <= 1'b0;
            sram_we       <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (mem_read || mem_write) begin
                        word  <= addr[SRAM_AW-2:0];
                        wdata <= mem_write_data;
                        if (nxm_addr) begin
                            state   <= NXM;
                            mem_nxm <= 1'b1;
                        end else if (mem_read) begin
                            state     <= RHI;
                            sram_en   <= 1'b1;
                            sram_addr <= {addr[SRAM_AW-2:0], 1'b0};
                        end else begin
                            state      <= WHI;
                            sram_en    <= 1'b1;
                            sram_we    <= 1'b1;
                            sram_addr  <= {addr[SRAM_AW-2:0], 1'b0};
                            sram_wdata <= mem_write_data[0:17];
                        end
                    end
                end
                RHI: begin
                    state <= RWH;
                    cnt   <= LAT;
                end
                RWH: begin
                    if (cnt == 3'd1) begin
                        mem_read_data[0:17] <= sram_rdata;
                        state     <= RLO;
                        sram_en   <= 1'b1;
                        sram_addr <= {word, 1'b1};
                    end else begin
                        cnt <= cnt - 3'd1;
                    end
                end
                RLO: begin
                    state <= RWL;
                    cnt   <= LAT;
                end
                RWL: begin
                    if (cnt == 3'd1) begin
                        mem_read_data[18:35] <= sram_rdata;
                        state        <= ACK;
                        mem_read_ack <= 1'b1;
                    end else begin
                        cnt <= cnt - 3'd1;
                    end
                end
                WHI: begin
                    state      <= WLO;
                    sram_en    <= 1'b1;
                    sram_we    <= 1'b1;
                    sram_addr  <= {word, 1'b1};
                    sram_wdata <= wdata[18:35];
                end
                WLO: begin
                    state         <= ACK;
                    mem_write_ack <= 1'b1;
                end
                ACK:     state <= IDLE;
                NXM:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_sram36.sv
// Randomized bench for mem_sram36 (RD_LAT=1 and RD_LAT=3 instances) against a
// word-level transaction model plus directed latency/data pins.
module tb_mem_sram36;

    localparam int MW = 262144;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]  rst = 2'b00;
    logic [1:0]  rd = 2'b00;
    logic [1:0]  wr = 2'b00;
    logic [21:0] addr [2];
    logic [35:0] wd [2];
    logic [35:0] rdat [2];
    logic [1:0]  rack, wack, nxm, en, we;
    logic [18:0] sa [2];
    logic [17:0] swd [2];
    logic [17:0] srd0, srd1;
    logic [17:0] pipe [2][8];

    mem_sram36 #(.MEMWORDS(MW), .SRAM_AW(19), .RD_LAT(1)) u0 (
        .clk(clk), .reset(rst[0]), .mem_addr(addr[0]),
        .mem_write_data(wd[0]), .mem_read(rd[0]), .mem_write(wr[0]),
        .mem_read_data(rdat[0]), .mem_read_ack(rack[0]),
        .mem_write_ack(wack[0]), .mem_nxm(nxm[0]), .sram_addr(sa[0]),
        .sram_wdata(swd[0]), .sram_rdata(srd0), .sram_en(en[0]),
        .sram_we(we[0])
    );

    mem_sram36 #(.MEMWORDS(MW), .SRAM_AW(19), .RD_LAT(3)) u1 (
        .clk(clk), .reset(rst[1]), .mem_addr(addr[1]),
        .mem_write_data(wd[1]), .mem_read(rd[1]), .mem_write(wr[1]),
        .mem_read_data(rdat[1]), .mem_read_ack(rack[1]),
        .mem_write_ack(wack[1]), .mem_nxm(nxm[1]), .sram_addr(sa[1]),
        .sram_wdata(swd[1]), .sram_rdata(srd1), .sram_en(en[1]),
        .sram_we(we[1])
    );

    // SRAM: 18-bit half-words, read data appears RD_LAT cycles after the strobe
    logic [17:0] sm [int unsigned];
    assign srd0 = pipe[0][0];
    assign srd1 = pipe[1][2];

    always @(posedge clk) begin
        int unsigned k;
        for (int i = 0; i < 2; i++) begin
            k = (32'(i) << 19) + 32'(sa[i]);
            if (en[i] && we[i]) sm[k] = swd[i];
            if (en[i] && !we[i])
                pipe[i][0] <= sm.exists(k) ? sm[k] : 18'h0;
            else
                pipe[i][0] <= 18'h2AAAA;
            for (int j = 1; j < 8; j++) pipe[i][j] <= pipe[i][j-1];
        end
    end

    function automatic logic [17:0] smget(input int i, input int unsigned a);
        int unsigned k;
        k = (32'(i) << 19) + a;
        return sm.exists(k) ? sm[k] : 18'h0;
    endfunction

    // Transaction model: whole 36-bit words, one outstanding op per instance
    logic [35:0] wm [int unsigned];
    int          cyc = 0;
    bit          pv [2];
    int          pop [2];
    int          pt0 [2];
    int          pev [2];
    int          free_at [2];
    logic [21:0] pa [2];
    logic [35:0] pwd [2];
    logic [35:0] pdat [2];
    logic [35:0] last [2];

    function automatic int lat_of(input int i);
        return (i == 0) ? 1 : 3;
    endfunction

    function automatic int unsigned wkey(input int i, input logic [21:0] a);
        return (32'(i) << 22) + 32'(a);
    endfunction

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (!rst[i]) begin
                pv[i]      = 1'b0;
                free_at[i] = cyc + 1;
                last[i]    = '0;
            end else begin
                if (pv[i] && cyc == pev[i]) begin
                    if (pop[i] == 0) last[i] = pdat[i];
                    pv[i] = 1'b0;
                end
                if (!pv[i] && cyc >= free_at[i] && (rd[i] || wr[i])) begin
                    pv[i]  = 1'b1;
                    pt0[i] = cyc;
                    pa[i]  = addr[i];
                    pwd[i] = wd[i];
                    if (int'(addr[i]) >= MW) begin
                        pop[i] = 2;
                        pev[i] = cyc + 1;
                    end else if (rd[i]) begin
                        pop[i]  = 0;
                        pev[i]  = cyc + 3 + 2 * lat_of(i);
                        pdat[i] = wm.exists(wkey(i, addr[i])) ?
                                  wm[wkey(i, addr[i])] : 36'h0;
                    end else begin
                        pop[i] = 1;
                        pev[i] = cyc + 3;
                        wm[wkey(i, addr[i])] = wd[i];
                    end
                    free_at[i] = pev[i] + 1;
                end
            end
        end
        cyc++;
    end

    int nchk = 0;
    int nerr = 0;

    task automatic check(input string nm, input int i,
                         input logic [63:0] act, input logic [63:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s[u%0d] cyc=%0d got=%0h want=%0h",
                     nm, i, cyc, act, exp);
        end
    endtask

    task automatic compare_cycle();
        for (int i = 0; i < 2; i++) begin
            bit xr, xw, xn, xhi, xen;
            xr  = pv[i] && pop[i] == 0 && cyc == pev[i];
            xw  = pv[i] && pop[i] == 1 && cyc == pev[i];
            xn  = pv[i] && pop[i] == 2 && cyc == pev[i];
            xhi = pv[i] && pop[i] != 2 && cyc == pt0[i] + 1;
            xen = xhi || (pv[i] && pop[i] == 0 &&
                          cyc == pt0[i] + 2 + lat_of(i))
                      || (pv[i] && pop[i] == 1 && cyc == pt0[i] + 2);
            check("read_ack", i, 64'(rack[i]), 64'(xr));
            check("write_ack", i, 64'(wack[i]), 64'(xw));
            check("nxm", i, 64'(nxm[i]), 64'(xn));
            check("sram_en", i, 64'(en[i]), 64'(xen));
            check("sram_we", i, 64'(we[i]), 64'(xen && pop[i] == 1));
            if (xen) begin
                check("sram_addr", i, 64'(sa[i]), 64'({pa[i][17:0], !xhi}));
                if (pop[i] == 1)
                    check("sram_wdata", i, 64'(swd[i]),
                          64'(xhi ? pwd[i][35:18] : pwd[i][17:0]));
            end
            if (xr)
                check("read_data", i, 64'(rdat[i]), 64'(pdat[i]));
            else if (!(pv[i] && pop[i] == 0))
                check("read_data_hold", i, 64'(rdat[i]), 64'(last[i]));
        end
    endtask

    task automatic req(input int i, input bit r, input bit w,
                       input logic [21:0] a, input logic [35:0] d,
                       input int hold, output int lat);
        int t0;
        bit done;
        rd[i] = r; wr[i] = w; addr[i] = a; wd[i] = d;
        t0 = cyc;
        done = 1'b0;
        for (int k = 0; k < 60 && !done; k++) begin
            @(negedge clk);
            if (k + 1 >= hold) begin rd[i] = 1'b0; wr[i] = 1'b0; end
            if (rack[i] || wack[i] || nxm[i]) done = 1'b1;
        end
        rd[i] = 1'b0; wr[i] = 1'b0;
        lat = cyc - t0;
        check("req_done", i, 64'(done), 64'(1));
    endtask

    task automatic run_random(input int i, input int n);
        int kind, hold, gap, lat;
        logic [21:0] a;
        logic [35:0] d;
        for (int t = 0; t < n; t++) begin
            kind = $urandom_range(0, 9);
            a = 22'($urandom_range(0, 63));
            if ($urandom_range(0, 9) == 0) a = 22'(MW - 1);
            if (kind >= 8)
                a = ($urandom_range(0, 3) == 0) ? 22'h3FFFFF :
                    22'(MW + $urandom_range(0, 3));
            d = {4'($urandom), $urandom};
            hold = ($urandom_range(0, 3) == 0) ? 1 : 1000;
            gap = $urandom_range(0, 2);
            if (hold == 1 && gap == 0) gap = 1;
            repeat (gap) @(negedge clk);
            req(i, kind < 4 || kind == 7 || kind == 8,
                (kind >= 4 && kind <= 7) || kind == 9, a, d, hold, lat);
        end
    endtask

    task automatic check_zero(input int i);
        check("rst_read_ack", i, 64'(rack[i]), 64'(0));
        check("rst_write_ack", i, 64'(wack[i]), 64'(0));
        check("rst_nxm", i, 64'(nxm[i]), 64'(0));
        check("rst_sram_en", i, 64'(en[i]), 64'(0));
        check("rst_sram_we", i, 64'(we[i]), 64'(0));
        check("rst_read_data", i, 64'(rdat[i]), 64'(0));
        check("rst_sram_addr", i, 64'(sa[i]), 64'(0));
        check("rst_sram_wdata", i, 64'(swd[i]), 64'(0));
    endtask

    logic [35:0] line [4];
    int lat, n, first, lastack, extra;

    initial begin
        line[0] = 36'o111111222222;
        line[1] = 36'o333333444444;
        line[2] = 36'o555555666666;
        line[3] = 36'o777777000001;
        for (int i = 0; i < 2; i++) begin
            addr[i] = '0;
            wd[i]   = '0;
        end
        fork
            forever begin
                @(negedge clk);
                compare_cycle();
            end
        join_none

        repeat (3) @(negedge clk);
        check_zero(0);
        check_zero(1);
        rst = 2'b11;
        @(negedge clk);

        req(0, 1'b0, 1'b1, 22'd5, 36'o123456701234, 1000, lat);
        check("wr_latency", 0, 64'(lat), 64'(3));
        check("sram_hi_10", 0, 64'(smget(0, 10)), 64'(18'o123456));
        check("sram_lo_11", 0, 64'(smget(0, 11)), 64'(18'o701234));
        @(negedge clk);
        req(0, 1'b1, 1'b0, 22'd5, 36'h0, 1000, lat);
        check("rd_latency", 0, 64'(lat), 64'(5));
        check("rd_data_5", 0, 64'(rdat[0]), 64'(36'o123456701234));
        @(negedge clk);

        req(0, 1'b1, 1'b0, 22'(MW), 36'h0, 1000, lat);
        check("nxm_latency", 0, 64'(lat), 64'(1));
        check("nxm_pulse", 0, 64'(nxm[0]), 64'(1));
        check("nxm_no_ack", 0, 64'(rack[0]), 64'(0));
        check("nxm_data_kept", 0, 64'(rdat[0]), 64'(36'o123456701234));
        @(negedge clk);

        for (int j = 0; j < 4; j++) begin
            req(0, 1'b0, 1'b1, 22'(8 + j), line[j], 1000, lat);
            @(negedge clk);
        end
        rd[0] = 1'b1;
        addr[0] = 22'd8;
        n = 0; first = 0; lastack = 0;
        for (int k = 0; k < 100 && n < 4; k++) begin
            @(negedge clk);
            if (rack[0]) begin
                check("line_data", 0, 64'(rdat[0]), 64'(line[n]));
                if (n == 0) first = cyc;
                lastack = cyc;
                n++;
                addr[0] = 22'(8 + n);
            end
        end
        rd[0] = 1'b0;
        check("line_acks", 0, 64'(n), 64'(4));
        check("line_span", 0, 64'(lastack - first), 64'(18));
        extra = 0;
        repeat (12) begin
            @(negedge clk);
            if (rack[0]) extra++;
        end
        check("line_extra", 0, 64'(extra), 64'(0));

        req(0, 1'b1, 1'b1, 22'd8, 36'o7, 1000, lat);
        check("both_latency", 0, 64'(lat), 64'(5));
        check("both_is_read", 0, 64'(rack[0]), 64'(1));
        check("both_data", 0, 64'(rdat[0]), 64'(line[0]));
        check("both_no_write", 0, 64'(smget(0, 17)), 64'(line[0][17:0]));
        @(negedge clk);

        wr[0] = 1'b1; addr[0] = 22'd1000; wd[0] = 36'o246;
        @(negedge clk);
        @(negedge clk);
        check("wlo_we", 0, 64'(we[0]), 64'(1));
        check("wlo_addr", 0, 64'(sa[0]), 64'(19'd2001));
        rst[0] = 1'b0; wr[0] = 1'b0;
        @(negedge clk);
        check_zero(0);
        rst[0] = 1'b1;
        @(negedge clk);
        req(0, 1'b1, 1'b0, 22'd5, 36'h0, 1000, lat);
        check("post_rst_latency", 0, 64'(lat), 64'(5));
        check("post_rst_data", 0, 64'(rdat[0]), 64'(36'o123456701234));

        run_random(0, 250);

        @(negedge clk);
        req(1, 1'b0, 1'b1, 22'd3, 36'o765432101234, 1000, lat);
        check("l3_wr_latency", 1, 64'(lat), 64'(3));
        @(negedge clk);
        req(1, 1'b1, 1'b0, 22'd3, 36'h0, 1000, lat);
        check("l3_rd_latency", 1, 64'(lat), 64'(9));
        check("l3_rd_data", 1, 64'(rdat[1]), 64'(36'o765432101234));
        run_random(1, 80);

        repeat (4) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule
